// File: rtl/histo_th_ctrl.sv
// Histogram SRAM sequencer: clear, accumulate a pixel histogram, then scan the cumulative sums into
// quantizer thresholds. Optional sticky saturation flag port: define HISTO_TH_CTRL_SAT_FLAG_EN.
module histo_th_ctrl #(
  parameter int P_DEPTH_BIT      = 8,
  parameter int P_DEPTH_SIZE_BIT = 10,
  parameter int P_TH_NUM         = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [P_DEPTH_SIZE_BIT:0]       num_pix,
  input  logic                            pix_vld,
  output logic                            pix_rdy,
  input  logic [P_DEPTH_BIT-1:0]          pix_data,
  output logic                            hs_cs,
  output logic                            hs_we,
  output logic [P_DEPTH_BIT-1:0]          hs_a,
  output logic [P_DEPTH_SIZE_BIT-1:0]     hs_d,
  input  logic [P_DEPTH_SIZE_BIT-1:0]     hs_q,
  output logic                            busy,
  output logic                            done,
`ifdef HISTO_TH_CTRL_SAT_FLAG_EN
  output logic                            sat_flag,
`endif
  output logic [P_TH_NUM*P_DEPTH_BIT-1:0] th
);

  localparam int CW = P_DEPTH_SIZE_BIT + 1;
  localparam int LV = P_TH_NUM + 1;
  localparam int PW = CW + $clog2(LV);
  localparam int AW = P_DEPTH_BIT + 1;
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);
  localparam logic [AW-1:0] CNT_LAST = AW'((1 << P_DEPTH_BIT) - 1);
  localparam logic [AW-1:0] CNT_END  = AW'(1 << P_DEPTH_BIT);
  localparam logic [CW-1:0] PIX_ONE  = CW'(1);
  localparam logic [P_DEPTH_SIZE_BIT-1:0] BIN_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACC_RD = 3'd2,
    S_ACC_WR = 3'd3,
    S_SCAN   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  typedef logic [P_TH_NUM-1:0][P_DEPTH_BIT-1:0] th_arr_t;

  function automatic logic [P_DEPTH_SIZE_BIT-1:0] sat_inc(input logic [P_DEPTH_SIZE_BIT-1:0] v);
    if (v == BIN_MAX) begin
      return v;
    end else begin
      return v + 1'b1;
    end
  endfunction

  // Level k is reached once cum/num_pix >= (k+1)/LV; cross-multiplied so no division is needed.
  function automatic logic reached(input logic [CW-1:0] cum, input int k, input logic [CW-1:0] num);
    return (PW'(cum) * PW'(LV)) >= (PW'(k + 1) * PW'(num));
  endfunction

  state_t               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        num_q, num_d;
  logic [CW-1:0]        pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]        cum_q, cum_d, cum_new_s;
  logic [P_DEPTH_BIT-1:0] wr_addr_q, wr_addr_d, scan_bin_s;
  th_arr_t              th_q, th_d, acc_q, acc_d, acc_new_s;
  logic [P_TH_NUM-1:0]  set_q, set_d, set_new_s;
`ifdef HISTO_TH_CTRL_SAT_FLAG_EN
  logic                 sat_q, sat_d;
`endif

  // Threshold search for the bin whose count is arriving on hs_q this cycle.
  always_comb begin
    cum_new_s  = cum_q + CW'(hs_q);
    scan_bin_s = P_DEPTH_BIT'(cnt_q - CNT_ONE);
    acc_new_s  = acc_q;
    set_new_s  = set_q;
    for (int k = 0; k < P_TH_NUM; k++) begin
      if (!set_q[k] && reached(cum_new_s, k, num_q)) begin
        acc_new_s[k] = scan_bin_s;
        set_new_s[k] = 1'b1;
      end else begin
        acc_new_s[k] = acc_q[k];
        set_new_s[k] = set_q[k];
      end
    end
  end

  // Next-state and SRAM port decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    pix_cnt_d = pix_cnt_q;
    cum_d     = cum_q;
    wr_addr_d = wr_addr_q;
    acc_d     = acc_q;
    set_d     = set_q;
    th_d      = th_q;
`ifdef HISTO_TH_CTRL_SAT_FLAG_EN
    sat_d     = sat_q;
`endif
    hs_cs     = 1'b0;
    hs_we     = 1'b0;
    hs_a      = '0;
    hs_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLEAR;
          num_d     = num_pix;
          cnt_d     = '0;
          pix_cnt_d = '0;
          cum_d     = '0;
          set_d     = '0;
`ifdef HISTO_TH_CTRL_SAT_FLAG_EN
          sat_d     = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        hs_cs = 1'b1;
        hs_we = 1'b1;
        hs_a  = cnt_q[P_DEPTH_BIT-1:0];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = (num_q == '0) ? S_SCAN : S_ACC_RD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ACC_RD: begin
        if (pix_vld) begin
          hs_cs     = 1'b1;
          hs_a      = pix_data;
          wr_addr_d = pix_data;
          state_d   = S_ACC_WR;
        end else begin
          state_d = S_ACC_RD;
        end
      end
      S_ACC_WR: begin
        hs_cs     = 1'b1;
        hs_we     = 1'b1;
        hs_a      = wr_addr_q;
        hs_d      = sat_inc(hs_q);
        pix_cnt_d = pix_cnt_q + PIX_ONE;
`ifdef HISTO_TH_CTRL_SAT_FLAG_EN
        if (hs_q == BIN_MAX) begin
          sat_d = 1'b1;
        end else begin
          sat_d = sat_q;
        end
`endif
        if (pix_cnt_d == num_q) begin
          state_d = S_SCAN;
        end else begin
          state_d = S_ACC_RD;
        end
      end
      S_SCAN: begin
        // Reads run one bin ahead of the data, so bin n is evaluated at count n+1.
        if (cnt_q < CNT_END) begin
          hs_cs = 1'b1;
          hs_a  = cnt_q[P_DEPTH_BIT-1:0];
        end else begin
          hs_cs = 1'b0;
        end
        if (cnt_q != '0) begin
          cum_d = cum_new_s;
          acc_d = acc_new_s;
          set_d = set_new_s;
        end else begin
          cum_d = cum_q;
        end
        if (cnt_q == CNT_END) begin
          state_d = S_DONE;
          for (int k = 0; k < P_TH_NUM; k++) begin
            th_d[k] = set_new_s[k] ? acc_new_s[k] : '1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      num_q     <= '0;
      pix_cnt_q <= '0;
      cum_q     <= '0;
      wr_addr_q <= '0;
      acc_q     <= '0;
      set_q     <= '0;
      th_q      <= '1;
`ifdef HISTO_TH_CTRL_SAT_FLAG_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      pix_cnt_q <= pix_cnt_d;
      cum_q     <= cum_d;
      wr_addr_q <= wr_addr_d;
      acc_q     <= acc_d;
      set_q     <= set_d;
      th_q      <= th_d;
`ifdef HISTO_TH_CTRL_SAT_FLAG_EN
      sat_q     <= sat_d;
`endif
    end
  end

  assign pix_rdy = (state_q == S_ACC_RD);
  assign busy    = (state_q == S_CLEAR) || (state_q == S_ACC_RD) ||
                   (state_q == S_ACC_WR) || (state_q == S_SCAN);
  assign done    = (state_q == S_DONE);
  assign th      = th_q;
`ifdef HISTO_TH_CTRL_SAT_FLAG_EN
  assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_histo_th_ctrl.sv
// Directed bench for histo_th_ctrl with a behavioural 256x10 histogram SRAM and a pixel source.
module tb_histo_th_ctrl;

  localparam int DB = 8;
  localparam int DW = 10;
  localparam int TN = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [DW:0]      num_pix = '0;
  logic             pix_vld = 1'b0;
  logic             pix_rdy;
  logic [DB-1:0]    pix_data = '0;
  logic             hs_cs, hs_we;
  logic [DB-1:0]    hs_a;
  logic [DW-1:0]    hs_d;
  logic [DW-1:0]    hs_q = '0;
  logic             busy, done;
  logic [TN*DB-1:0] th;
`ifdef HISTO_TH_CTRL_SAT_FLAG_EN
  logic             sat_flag;
`endif

  histo_th_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_pix  (num_pix),
    .pix_vld  (pix_vld),
    .pix_rdy  (pix_rdy),
    .pix_data (pix_data),
    .hs_cs    (hs_cs),
    .hs_we    (hs_we),
    .hs_a     (hs_a),
    .hs_d     (hs_d),
    .hs_q     (hs_q),
    .busy     (busy),
    .done     (done),
`ifdef HISTO_TH_CTRL_SAT_FLAG_EN
    .sat_flag (sat_flag),
`endif
    .th       (th)
  );

  always #5 clk = ~clk;

  // SRAM model; garbage is written while reset is held so the clear phase matters.
  logic [DW-1:0] mem [256];
  logic [DB-1:0] fill_idx = '0;
  always @(posedge clk) begin
    if (rst) begin
      mem[fill_idx] <= DW'($urandom);
      fill_idx      <= fill_idx + 8'd1;
    end else if (hs_cs) begin
      if (hs_we) mem[hs_a] <= hs_d;
      else       hs_q      <= mem[hs_a];
    end
  end

  int  cur_num = 0, cur_mode = 0, cur_val = 0;
  bit  cur_tog = 1'b0, stream_on = 1'b0;
  int  run_id = 0, seen_id = 0;
  int  accepted = 0;
  int  wr_cnt = 0, wr_err = 0, bad_a = 0, bad_d = 0;
  bit  phase = 1'b0;

  function automatic logic [DB-1:0] pix_of(input int i);
    if (cur_mode == 0) return DB'(cur_val + i);
    else               return DB'(cur_val);
  endfunction

  always @(posedge clk) begin
    if (rst || (start && !busy)) accepted <= 0;
    else if (pix_vld && pix_rdy) accepted <= accepted + 1;
  end

  // Write monitor (ACCUM writes are the only nonzero ones) and pixel source.
  always @(negedge clk) begin
    int exp_d;
    if (run_id != seen_id) begin
      seen_id = run_id;
      wr_cnt  = 0;
      wr_err  = 0;
    end
    if (hs_cs && hs_we && hs_d != '0) begin
      exp_d = (cur_mode == 0) ? 1 : ((wr_cnt + 1 > 1023) ? 1023 : wr_cnt + 1);
      if (hs_a != pix_of(wr_cnt) || hs_d != DW'(exp_d)) begin
        if (wr_err == 0) begin
          bad_a = int'(hs_a);
          bad_d = int'(hs_d);
        end
        wr_err++;
      end
      wr_cnt++;
    end
    phase    = ~phase;
    pix_vld  = stream_on && (accepted < cur_num) && (!cur_tog || phase);
    pix_data = pix_of(accepted);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_near(input string nm, input int act, input int exp);
    checks++;
    if (act < exp - 1 || act > exp + 1) begin
      errors++;
      $display("FAIL %s: got %0d cycles, expected %0d (+/-1)", nm, act, exp);
    end
  endtask

  typedef struct {
    int               num;
    int               mode;   // 0: pixel = val + index, 1: pixel = val
    int               val;
    bit               tog;
    logic [TN*DB-1:0] th;
    int               cyc;    // start-to-done cycles, 0 = not checked
    bit               sat;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v, input int pulse_at);
    int cyc, busy_bad, th_bad, rdy_cnt, extra_done, extra_busy;
    bit got_done;
    logic [TN*DB-1:0] th0;
    cur_num = v.num; cur_mode = v.mode; cur_val = v.val; cur_tog = v.tog;
    run_id = run_id + 1;
    stream_on = 1'b1;
    @(negedge clk);
    num_pix = (DW+1)'(v.num);
    start   = 1'b1;
    th0     = th;
    @(negedge clk);
    start   = 1'b0;
    num_pix = '0;
    cyc = 1; got_done = 1'b0; busy_bad = 0; th_bad = 0; rdy_cnt = 0;
    while (!got_done && cyc < 6000) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (!busy) busy_bad++;
        if (th !== th0) th_bad++;
        if (pix_rdy) rdy_cnt++;
        start = (cyc == pulse_at);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk($sformatf("v%0d_done_seen", idx), 64'(got_done), 64'd1);
    if (v.cyc != 0) chk_near($sformatf("v%0d_latency", idx), cyc, v.cyc);
    chk($sformatf("v%0d_busy_gaps", idx), 64'(busy_bad), 64'd0);
    chk($sformatf("v%0d_th_stable", idx), 64'(th_bad), 64'd0);
    chk($sformatf("v%0d_busy_at_done", idx), 64'(busy), 64'd0);
    chk($sformatf("v%0d_th", idx), 64'(th), 64'(v.th));
    chk($sformatf("v%0d_wr_count", idx), 64'(wr_cnt), 64'(v.num));
    if (wr_err != 0)
      $display("FAIL v%0d_wr_data: %0d bad writes, first addr %0d data %0d", idx, wr_err, bad_a, bad_d);
    chk($sformatf("v%0d_wr_errors", idx), 64'(wr_err), 64'd0);
    if (!v.tog) chk($sformatf("v%0d_rdy_cycles", idx), 64'(rdy_cnt), 64'(v.num));
`ifdef HISTO_TH_CTRL_SAT_FLAG_EN
    chk($sformatf("v%0d_sat_flag", idx), 64'(sat_flag), 64'(v.sat));
`endif
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), 64'(done), 64'd0);
    chk($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'd0);
    if (pulse_at > 0) begin
      extra_done = 0; extra_busy = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) extra_done++;
        if (busy) extra_busy++;
      end
      chk($sformatf("v%0d_extra_done", idx), 64'(extra_done), 64'd0);
      chk($sformatf("v%0d_extra_busy", idx), 64'(extra_busy), 64'd0);
    end
    stream_on = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    int cyc;
    vecs[0] = '{8,    0, 0,   1'b0, 56'h06050403020100, 530,  1'b0};
    vecs[1] = '{16,   1, 100, 1'b1, 56'h64646464646464, 0,    1'b0};
    vecs[2] = '{1024, 1, 3,   1'b0, 56'h03030303030303, 2562, 1'b1};
    vecs[3] = '{0,    1, 0,   1'b0, 56'h00000000000000, 514,  1'b0};
    vecs[4] = '{7,    0, 50,  1'b0, 56'h38373635343332, 528,  1'b0};
    vecs[5] = '{2047, 1, 200, 1'b0, 56'hFFFFFFFFC8C8C8, 4608, 1'b1};
    vecs[6] = '{1,    1, 255, 1'b0, 56'hFFFFFFFFFFFFFF, 516,  1'b0};

    rst = 1'b1;
    repeat (260) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pix_rdy", 64'(pix_rdy), 64'd0);
    chk("rst_hs_cs",   64'(hs_cs),   64'd0);
    chk("rst_hs_we",   64'(hs_we),   64'd0);
    chk("rst_hs_a",    64'(hs_a),    64'd0);
    chk("rst_hs_d",    64'(hs_d),    64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_done",    64'(done),    64'd0);
    chk("rst_th",      64'(th),      64'h00FFFFFFFFFFFFFF);
`ifdef HISTO_TH_CTRL_SAT_FLAG_EN
    chk("rst_sat_flag", 64'(sat_flag), 64'd0);
`endif

    run_vec(0, vecs[0], 0);

    // Abort a run with reset while it is accumulating.
    cur_num = 16; cur_mode = 1; cur_val = 100; cur_tog = 1'b0;
    run_id = run_id + 1;
    stream_on = 1'b1;
    @(negedge clk);
    num_pix = 11'd16;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (accepted < 4 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_accum", 64'(accepted >= 4), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stream_on = 1'b0;
    @(negedge clk);
    chk("abort_pix_rdy", 64'(pix_rdy), 64'd0);
    chk("abort_busy",    64'(busy),    64'd0);
    chk("abort_hs_cs",   64'(hs_cs),   64'd0);
    chk("abort_th",      64'(th),      64'h00FFFFFFFFFFFFFF);

    for (int i = 1; i < 7; i++) run_vec(i, vecs[i], 0);

    // Start pulse during SCAN must be ignored.
    run_vec(7, vecs[0], 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/histo_th_ctrl.md
Name: histo_th_ctrl

Overview:
- Sequences the histogram SRAM (256 x 10) through three phases: clear, histogram accumulation from an incoming pixel stream, and a cumulative-sum scan.
- The scan produces the 7 quantization thresholds (8 output levels, 3-bit quantized pixels) that drive the quantizer.
- Sits between the pixel source (image SRAM reader) and the histo SRAM.
- It is the only master of the histo SRAM while busy.

Parameters:
- P_DEPTH_BIT, 8, input pixel width; histo SRAM address width; 2**P_DEPTH_BIT bins
- P_DEPTH_SIZE_BIT, 10, histo SRAM data width; max pixels = 2**P_DEPTH_SIZE_BIT
- P_TH_NUM, 7, number of thresholds (P_TH_NUM+1 = 8 levels)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a run when idle
- num_pix  in  P_DEPTH_SIZE_BIT+1  pixel count of the frame; sampled on accepted start
- pix_vld  in  1  pixel valid
- pix_rdy  out  1  pixel ready
- pix_data  in  P_DEPTH_BIT  pixel value
- hs_cs  out  1  histo SRAM chip select
- hs_we  out  1  histo SRAM write enable
- hs_a  out  P_DEPTH_BIT  histo SRAM address
- hs_d  out  P_DEPTH_SIZE_BIT  histo SRAM write data
- hs_q  in  P_DEPTH_SIZE_BIT  histo SRAM read data, valid 1 cycle after read
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when thresholds are valid
- th  out  P_TH_NUM*P_DEPTH_BIT  packed thresholds; th[k] occupies bits [8k+7:8k]

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high. The polarity and synchronicity are fixed.
- Reset values: state=IDLE; pix_rdy, hs_cs, hs_we, busy, done = 0; hs_a, hs_d = 0; th = all 0xFF.
- Reset mid-operation aborts the run. SRAM contents are don't-care.
- IDLE:
  - start=1 latches num_pix, sets busy, and goes to CLEAR.
  - start while busy is ignored.
  - th holds the last result.
- CLEAR: 256 cycles. Each cycle hs_cs=hs_we=1, hs_d=0, and hs_a counts 0..255.
  - After address 255, go to ACCUM.
  - If num_pix=0, go to SCAN instead.
- ACCUM: 2-cycle slot per pixel.
  - Read slot: pix_rdy=1. On pix_vld&pix_rdy, issue a read (hs_cs=1, hs_we=0, hs_a=pix_data) and register the address.
  - Write slot: pix_rdy=0. Write hs_q+1 to the registered address. Saturate at 2**P_DEPTH_SIZE_BIT-1.
  - If pix_vld is low in the read slot, stay in the read slot.
  - After the num_pix-th write, go to SCAN.
  - No read/write hazard exists because slots never overlap.
- SCAN: reads bins 0..255 sequentially, back to back. Data arrives one cycle later, so the scan takes 257 cycles.
  - cum (P_DEPTH_SIZE_BIT+1 bits, cleared on SCAN entry) += hs_q.
  - For each k in 0..6 not yet set: if cum_new*8 >= (k+1)*num_pix, then th[k] = current bin index.
  - Several k may be set in the same cycle.
  - Any k still unset at the end is set to 0xFF.
  - All th bits update together when entering DONE. th is stable while busy.
- DONE: 1 cycle. done=1, busy=0 on this cycle, then return to IDLE.
- When not in CLEAR, ACCUM or SCAN, hs_cs=0.
- Arithmetic: the comparison uses 14-bit unsigned products, so there is no overflow.

Optional Feature:
- Macro HISTO_TH_CTRL_SAT_FLAG_EN.
- Defined: adds output port sat_flag (1 bit, reset 0).
  - Sticky; set when any ACCUM write saturates.
  - Cleared on accepted start.
- Undefined: no sat_flag port. Saturation still occurs silently.

Test Plan:
- Reset: assert rst for 2 cycles mid-ACCUM -> next cycle pix_rdy=0, busy=0, hs_cs=0, th=0xFFFFFFFFFFFFFF; a new start runs normally.
- num_pix=8, pixels 0,1,2,3,4,5,6,7 -> done after 256+16+257+1 cycles (±1); th[k]=k for k=0..6.
- num_pix=16, all pixels 100, pix_vld toggling every other cycle -> th[k]=100 for all k; hs_we writes to addr 100 with values 1..16.
- num_pix=1024, all pixels 3 -> bin 3 saturates at 1023; th[k]=3 for all k; sat_flag=1 if the macro is defined.
- num_pix=0 -> CLEAR then SCAN, with no pix_rdy; all th=0.
- start pulsed during SCAN -> ignored; single done pulse; busy stays high throughout.
